// File: rtl/key_matrix_scan.sv
// key_matrix_scan: column-scanned key matrix reader with debounce
// and a valid/ready key-code output towards the front-panel controller.
module key_matrix_scan #(
   parameter int COLS     = 4,
   parameter int ROWS     = 4,
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 8
) (
   input  logic                                   cp,
   input  logic                                   rst,
   input  logic [ROWS-1:0]                        rows,
   output logic [COLS-1:0]                        cols,
   output logic [$clog2(COLS)+$clog2(ROWS)-1:0]   key_code,
   output logic                                   key_valid,
   input  logic                                   key_ready,
   output logic                                   key_down,
   output logic                                   overflow
);

   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int DIVW = $clog2(SCAN_DIV);
   localparam int DW   = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

   state_t          state_q, state_d;
   logic [ROWS-1:0] rows_m_q, rows_s_q;
   logic [DIVW-1:0] div_q;
   logic [CW-1:0]   col_q, col_d;
   logic [DW-1:0]   deb_q, deb_d, deb_inc;
   logic [CW+RW-1:0] cap_q, cap_d;
   logic [COLS-1:0] cols_q;
   logic [CW+RW-1:0] key_code_q;
   logic            key_valid_q, overflow_q;
   logic [RW-1:0]   row_idx;
   logic            hit, tick, accept;
   logic [CW-1:0]   col_nxt;

   assign tick    = (div_q == DIVW'(SCAN_DIV - 1));
   assign hit     = ~&rows_s_q;
   assign deb_inc = deb_q + 1'b1;
   assign col_nxt = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;

   // two-flop synchroniser for the asynchronous row inputs
   always_ff @(posedge cp or negedge rst) begin
      if (!rst) begin
         rows_m_q <= '1;
         rows_s_q <= '1;
      end else begin
         rows_m_q <= rows;
         rows_s_q <= rows_m_q;
      end
   end

   // lowest active row wins
   always_comb begin
      row_idx = '0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (!rows_s_q[i]) row_idx = RW'(i);
   end

   // dwell divider; tick marks the last cycle of a column dwell
   always_ff @(posedge cp or negedge rst) begin
      if (!rst) div_q <= '0;
      else      div_q <= tick ? '0 : div_q + 1'b1;
   end

   // scan / debounce / held next-state logic, acting on ticks only
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      deb_d   = deb_q;
      cap_d   = cap_q;
      accept  = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_SCAN: begin
               if (hit) begin
                  cap_d = {col_q, row_idx};
                  deb_d = DW'(1);
                  if (DEBOUNCE == 1) begin
                     accept  = 1'b1;
                     deb_d   = '0;
                     state_d = S_HELD;
                  end else begin
                     state_d = S_DEB;
                  end
               end else begin
                  col_d = col_nxt;
               end
            end
            S_DEB: begin
               if (hit && row_idx == cap_q[RW-1:0]) begin
                  deb_d = deb_inc;
                  if (deb_inc == DW'(DEBOUNCE)) begin
                     accept  = 1'b1;
                     deb_d   = '0;
                     state_d = S_HELD;
                  end
               end else begin
                  deb_d   = '0;
                  col_d   = col_nxt;
                  state_d = S_SCAN;
               end
            end
            S_HELD: begin
               if (!hit) begin
                  deb_d = deb_inc;
                  if (deb_inc == DW'(DEBOUNCE)) begin
                     deb_d   = '0;
                     col_d   = col_nxt;
                     state_d = S_SCAN;
                  end
               end else begin
                  deb_d = '0;
               end
            end
            default: state_d = S_SCAN;
         endcase
      end
   end

   // FSM state, frozen column, debounce count and captured code
   always_ff @(posedge cp or negedge rst) begin
      if (!rst) begin
         state_q <= S_SCAN;
         col_q   <= '0;
         deb_q   <= '0;
         cap_q   <= '0;
         cols_q  <= '1;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         deb_q   <= deb_d;
         cap_q   <= cap_d;
         cols_q  <= ~(COLS'(1) << col_q);
      end
   end

   // key hand-off: load on accept when free, else drop and flag overflow
   always_ff @(posedge cp or negedge rst) begin
      if (!rst) begin
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         overflow_q <= 1'b0;
         if (accept) begin
            if (!key_valid_q || key_ready) begin
               key_code_q  <= cap_d;
               key_valid_q <= 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (key_valid_q && key_ready) begin
            key_valid_q <= 1'b0;
         end
      end
   end

   assign cols      = cols_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = (state_q == S_HELD);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: physical 4x4 matrix model driving the scanner,
// random presses and ready, checked every cycle against a key-level model.
module tb_key_matrix_scan;

   localparam int C  = 4;
   localparam int R  = 4;
   localparam int SD = 4;
   localparam int DB = 3;

   logic       cp, rst, key_ready;
   logic [3:0] rows_w, cols, key_code;
   logic       key_valid, key_down, overflow;
   logic [15:0] pk;

   int n_cmp = 0;
   int n_mis = 0;
   int ovf_seen = 0;

   key_matrix_scan #(
      .COLS(C), .ROWS(R), .SCAN_DIV(SD), .DEBOUNCE(DB)
   ) dut (
      .cp(cp), .rst(rst), .rows(rows_w), .cols(cols),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .key_down(key_down), .overflow(overflow)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   // switch matrix with pull-ups: a pressed key shorts its row to its column
   always_comb begin
      rows_w = 4'hF;
      for (int c = 0; c < C; c++)
         for (int r = 0; r < R; r++)
            if (pk[c*R+r] && !cols[c]) rows_w[r] = 1'b0;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // key-level model: phase 0 looking, 1 confirming, 2 held
   int m_s1, m_s2, m_div, m_col, m_cols, m_phase, m_run;
   int m_cap, m_code, m_valid, m_ovf;
   int seen, rowm, hitm, acc;

   always @(posedge cp or negedge rst) begin
      if (!rst) begin
         m_s1 = 15; m_s2 = 15; m_div = 0; m_col = 0; m_cols = 15;
         m_phase = 0; m_run = 0; m_cap = 0; m_code = 0;
         m_valid = 0; m_ovf = 0;
      end else begin
         seen = m_s2;
         hitm = (seen != 15);
         rowm = 0;
         for (int r = R - 1; r >= 0; r--)
            if (((seen >> r) & 1) == 0) rowm = r;
         acc = 0;
         m_ovf = 0;
         m_cols = 15 ^ (1 << m_col);
         if (m_div == SD - 1) begin
            if (m_phase == 0) begin
               if (hitm) begin
                  m_cap = m_col * R + rowm;
                  m_run = 1;
                  m_phase = 1;
               end else m_col = (m_col + 1) % C;
            end else if (m_phase == 1) begin
               if (hitm && rowm == m_cap % R) begin
                  m_run++;
                  if (m_run == DB) begin
                     acc = 1; m_run = 0; m_phase = 2;
                  end
               end else begin
                  m_phase = 0; m_run = 0; m_col = (m_col + 1) % C;
               end
            end else begin
               if (!hitm) begin
                  m_run++;
                  if (m_run == DB) begin
                     m_phase = 0; m_run = 0; m_col = (m_col + 1) % C;
                  end
               end else m_run = 0;
            end
         end
         if (acc) begin
            if (!m_valid || key_ready) begin
               m_code = m_cap; m_valid = 1;
            end else m_ovf = 1;
         end else if (m_valid && key_ready) m_valid = 0;
         m_s2 = m_s1;
         m_s1 = rows_w;
         m_div = (m_div + 1) % SD;
      end
   end

   // per-cycle compare against the model
   always @(negedge cp) begin
      if (rst) begin
         chk("cols", cols, m_cols);
         chk("key_valid", key_valid, m_valid);
         if (m_valid) chk("key_code", key_code, m_code);
         chk("key_down", key_down, m_phase == 2);
         chk("overflow", overflow, m_ovf);
         if (overflow) ovf_seen++;
      end
   end

   task automatic cyc(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge cp);
         if (rnd) key_ready = ($urandom_range(0, 2) == 0);
      end
   endtask

   task automatic wait_confirm();
      for (int i = 0; i < 400 && m_phase != 1; i++) @(negedge cp);
      chk("wait_confirm", m_phase, 1);
   endtask

   task automatic consume();
      key_ready = 1'b1;
      @(negedge cp);
      key_ready = 1'b0;
      chk("consume_valid", key_valid, 0);
   endtask

   int o0;

   initial begin
      rst = 1'b0; key_ready = 1'b0; pk = '0;
      cyc(3, 0);
      chk("rst_cols", cols, 4'hF);
      chk("rst_valid", key_valid, 0);
      rst = 1'b1;
      cyc(9, 0);
      rst = 1'b0;
      @(negedge cp);
      chk("midrst_cols", cols, 4'hF);
      chk("midrst_valid", key_valid, 0);
      rst = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         @(negedge cp);
         chk("walk", cols, 15 ^ (1 << (((n - 1) / 4) % 4)));
      end

      pk[2*R+1] = 1'b1;
      cyc(80, 0);
      chk("press_valid", key_valid, 1);
      chk("press_code", key_code, 4'h9);
      chk("press_down", key_down, 1);
      pk = '0;
      cyc(24, 0);
      chk("release_down", key_down, 0);
      chk("release_code", key_code, 4'h9);
      consume();

      pk[2*R+0] = 1'b1;
      wait_confirm();
      cyc(4, 0);
      pk = '0;
      cyc(40, 0);
      chk("bounce_valid", key_valid, 0);

      o0 = ovf_seen;
      pk[0] = 1'b1;
      cyc(60, 0);
      pk = '0;
      cyc(40, 0);
      pk[3*R+3] = 1'b1;
      cyc(60, 0);
      pk = '0;
      cyc(40, 0);
      chk("bp_code", key_code, 0);
      chk("bp_valid", key_valid, 1);
      chk("bp_ovf", ovf_seen - o0, 1);
      consume();

      pk[0*R+1] = 1'b1;
      pk[0*R+2] = 1'b1;
      cyc(60, 0);
      chk("multi_code", key_code, 4'h1);
      pk = '0;
      cyc(40, 0);
      consume();

      pk[1*R+3] = 1'b1;
      wait_confirm();
      rst = 1'b0;
      pk = '0;
      @(negedge cp);
      chk("debrst_cols", cols, 4'hF);
      chk("debrst_valid", key_valid, 0);
      rst = 1'b1;
      cyc(60, 0);
      chk("debrst_nokey", key_valid, 0);

      for (int e = 0; e < 60; e++) begin
         pk = '0;
         pk[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 3) == 0) pk[$urandom_range(0, 15)] = 1'b1;
         cyc($urandom_range(2, 60), 1);
         pk = '0;
         cyc($urandom_range(2, 50), 1);
      end
      key_ready = 1'b0;
      cyc(4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
